// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding, BCD
// digit limits, the time-of-count record and the 7-segment glyph table.
package stopwatch_pkg;

   // Controller states. Kept as plain 2-bit constants so older code that
   // compares against raw values keeps working.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_LAP   = 2'd3;

   // Largest value each BCD digit may hold before it rolls over.
   localparam logic [3:0] TENTHS_MAX   = 4'd9;
   localparam logic [3:0] SEC_ONES_MAX = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam logic [3:0] MINUTES_MAX  = 4'd9;

   // Elapsed time as M:SS.d, one BCD nibble per displayed digit.
   typedef struct packed {
      logic [3:0] minutes;
      logic [3:0] sec_tens;
      logic [3:0] sec_ones;
      logic [3:0] tenths;
   } bcd_time_t;

   localparam bcd_time_t TIME_ZERO = '0;

   // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Advance a time value by one tenth, rippling carries upward. The
   // minutes digit wraps silently, so 9:59.9 becomes 0:00.0.
   function automatic bcd_time_t bcd_time_inc(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.tenths != TENTHS_MAX) begin
         r.tenths = t.tenths + 4'd1;
      end else begin
         r.tenths = 4'd0;
         if (t.sec_ones != SEC_ONES_MAX) begin
            r.sec_ones = t.sec_ones + 4'd1;
         end else begin
            r.sec_ones = 4'd0;
            if (t.sec_tens != SEC_TENS_MAX) begin
               r.sec_tens = t.sec_tens + 4'd1;
            end else begin
               r.sec_tens = 4'd0;
               if (t.minutes != MINUTES_MAX) begin
                  r.minutes = t.minutes + 4'd1;
               end else begin
                  r.minutes = 4'd0;
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD-to-7-segment decoder. Codes 10-15 never occur in a
// valid count and are shown as a blank digit.
module bcd_to_7seg
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Table lookup of the glyph for one digit.
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and lap/clear keys drive a four-state
// FSM, a BCD M:SS.d counter advances on 0.1 s ticks, and a four-digit
// multiplexed 7-segment display is scanned from a 1 kHz strobe.
// dbg_state mirrors the FSM state register for observation.
module stopwatch_ctrl
   import stopwatch_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst,
   input  logic       clk_1kHz,
   input  logic       clk_10Hz,
   input  logic       key_start,
   input  logic       key_lap,
   output logic [3:0] digit_sel,
   output logic [6:0] seg_data,
   output logic       seg_dp,
   output logic       running,
   output logic [1:0] dbg_state
);

   // Previous samples for rising-edge detection.
   logic prev_1khz;
   logic prev_10hz;
   logic prev_start;
   logic prev_lap;

   // One-cycle pulses on each input's rising edge.
   logic scan_pulse;
   logic tick_pulse;
   logic start_pulse;
   logic lap_pulse;

   logic [1:0] state;
   logic [1:0] state_nxt;
   bcd_time_t  count_q;
   bcd_time_t  count_nxt;
   bcd_time_t  lap_q;
   bcd_time_t  lap_nxt;
   bcd_time_t  disp_time;
   logic [3:0] digit_bcd;

   assign scan_pulse  = clk_1kHz  & ~prev_1khz;
   assign tick_pulse  = clk_10Hz  & ~prev_10hz;
   assign start_pulse = key_start & ~prev_start;
   assign lap_pulse   = key_lap   & ~prev_lap;

   // Next-state, count and lap-capture logic. The tick is judged against
   // the registered state, so a tick landing on a transition cycle still
   // counts if the old state was counting. Start wins over lap.
   always_comb begin
      state_nxt = state;
      count_nxt = count_q;
      lap_nxt   = lap_q;

      if (tick_pulse && (state == ST_RUN || state == ST_LAP)) begin
         count_nxt = bcd_time_inc(count_q);
      end

      if (start_pulse) begin
         case (state)
            ST_IDLE:  state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_PAUSE;
            ST_LAP:   state_nxt = ST_PAUSE;
            ST_PAUSE: state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
         endcase
      end else if (lap_pulse) begin
         case (state)
            ST_RUN: begin
               state_nxt = ST_LAP;
               lap_nxt   = count_q;
            end
            ST_LAP: begin
               state_nxt = ST_RUN;
            end
            ST_PAUSE: begin
               state_nxt = ST_IDLE;
               count_nxt = TIME_ZERO;
            end
            default: begin
               state_nxt = state;
            end
         endcase
      end
   end

   // State, counter, lap register, edge history and scan position.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state      <= ST_IDLE;
         count_q    <= TIME_ZERO;
         lap_q      <= TIME_ZERO;
         prev_1khz  <= 1'b0;
         prev_10hz  <= 1'b0;
         prev_start <= 1'b0;
         prev_lap   <= 1'b0;
         digit_sel  <= 4'b0001;
      end else begin
         state      <= state_nxt;
         count_q    <= count_nxt;
         lap_q      <= lap_nxt;
         prev_1khz  <= clk_1kHz;
         prev_10hz  <= clk_10Hz;
         prev_start <= key_start;
         prev_lap   <= key_lap;
         if (scan_pulse) begin
            digit_sel <= {digit_sel[2:0], digit_sel[3]};
         end
      end
   end

   // Frozen lap time is shown only while in LAP.
   assign disp_time = (state == ST_LAP) ? lap_q : count_q;

   // Pick the BCD nibble for the digit currently being scanned.
   always_comb begin
      digit_bcd = 4'hF;
      case (digit_sel)
         4'b0001: digit_bcd = disp_time.tenths;
         4'b0010: digit_bcd = disp_time.sec_ones;
         4'b0100: digit_bcd = disp_time.sec_tens;
         4'b1000: digit_bcd = disp_time.minutes;
         default: digit_bcd = 4'hF;
      endcase
   end

   bcd_to_7seg u_dec (
      .bcd (digit_bcd),
      .seg (seg_data)
   );

   // Decimal point sits after the seconds-ones digit.
   assign seg_dp    = (digit_sel == 4'b0010);
   assign running   = (state == ST_RUN) || (state == ST_LAP);
   assign dbg_state = state;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have port: clk_in  input  1  1 MHz system clock; all logic on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: clk_1kHz  input  1  divider output, synchronous to clk_in; rising edge = display scan step.
REQ-004 SHALL have port: clk_10Hz  input  1  divider output, synchronous to clk_in; rising edge = one 0.1 s tick.
REQ-005 SHALL have port: key_start  input  1  start/stop key level, already debounced, active-high.
REQ-006 SHALL have port: key_lap  input  1  lap/clear key level, already debounced, active-high.
REQ-007 SHALL have port: digit_sel  output  4  one-hot digit enable, active-high; bit0 = tenths, bit1 = seconds ones, bit2 = seconds tens, bit3 = minutes.
REQ-008 SHALL have port: seg_data  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-009 SHALL have port: seg_dp  output  1  decimal point, active-high.
REQ-010 SHALL have port: running  output  1  high in RUN and LAP states.

Function
REQ-011 SHALL detect rising edges of clk_1kHz, clk_10Hz, key_start and key_lap with one previous-sample register each: pulse = current & ~previous, one clk_in cycle wide.
REQ-012 SHALL hold the elapsed time as BCD M:SS.d: tenths 0-9, sec_ones 0-9, sec_tens 0-5, minutes 0-9.
REQ-013 SHALL increment the count by 0.1 s on each clk_10Hz pulse while the state is RUN or LAP; the new value is visible the cycle after the pulse.
REQ-014 SHALL carry tenths 9->0 into sec_ones, sec_ones 9->0 into sec_tens, sec_tens 5->0 into minutes, and wrap 9:59.9 -> 0:00.0 with no flag and no stop.
REQ-015 SHALL implement states IDLE, RUN, PAUSE and LAP.
REQ-016 SHALL apply these transitions:
- IDLE: start -> RUN.
- RUN: start -> PAUSE; lap -> LAP, capturing the live count into the lap register in the same cycle.
- LAP: start -> PAUSE; lap -> RUN.
- PAUSE: start -> RUN; lap -> IDLE, clearing the count to 0:00.0.
- All other key pulses are ignored.
REQ-017 SHALL give key_start priority when both key pulses occur in the same cycle; the lap pulse is discarded.
REQ-018 SHALL apply a clk_10Hz pulse according to the state registered in that cycle, even when a transition occurs in the same cycle; for example, RUN + start + tick -> count increments, then PAUSE.
REQ-019 SHALL display the lap register in state LAP and the live count in all other states.
REQ-020 SHALL rotate digit_sel 0001 -> 0010 -> 0100 -> 1000 -> 0001 on each clk_1kHz pulse, in every state.
REQ-021 SHALL derive seg_data combinationally from the selected digit's BCD value with zero cycles of latency; BCD values 10-15 are unreachable and decode to 0000000.
REQ-022 SHALL assert seg_dp only while digit_sel = 0010.
REQ-023 SHALL drive running combinationally from the state register.

Reset
REQ-024 SHALL, on a clk_in edge with rst=1, set: state IDLE, count 0:00.0, lap register 0:00.0, all edge-detect registers 0, digit_sel 0001.
REQ-025 SHALL present the following outputs during and after reset: seg_data 0111111, seg_dp 0, running 0.
REQ-026 SHALL let rst override every key pulse and tick pulse in the same cycle, including a reset asserted mid-run or mid-lap.
REQ-027 SHALL treat an input sampled high on the first cycle after reset as a rising edge.

Structure
REQ-028 SHALL place the state encoding, the BCD limits (9, 5, 9, 9) and the 7-segment patterns for 0-9 in shared package stopwatch_pkg.
REQ-029 SHALL instantiate one sub-module, bcd_to_7seg: a 4-bit input, a 7-bit output, purely combinational.

Verification
REQ-030 SHALL cover reset: rst high for 2 cycles -> digit_sel=0001, seg_data=0111111, seg_dp=0, running=0.
REQ-031 SHALL cover counting: start pulse, then 10 clk_10Hz edges -> count 0:01.0, running=1; digits 0,1,0,0 shown as scan reaches bit0-bit3.
REQ-032 SHALL cover wrap: from IDLE, start, then 5999 ticks -> 9:59.9; one more tick -> 0:00.0 with running still 1.
REQ-033 SHALL cover lap: start, 25 ticks, lap pulse, 10 ticks -> display holds 0:02.5; lap pulse -> display 0:03.5, state RUN.
REQ-034 SHALL cover simultaneous keys: in RUN, start and lap pulses in the same cycle -> PAUSE and the lap register unchanged; then a lap pulse -> IDLE and count 0:00.0.
REQ-035 SHALL cover reset mid-run: rst in the same cycle as a tick at count 0:04.2 -> next cycle count 0:00.0, state IDLE, running=0.
